// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage integer pipeline.
// It arbitrates hold/flush requests from Id (load-use), Ex (jump, divider),
// Mem (data-bus wait) and the trap logic. It drives per-buffer hold/flush
// commands and the PC redirect.
// Bit mapping of HoldVec/FlushVec:
//   bit0 Pc, bit1 If2Id, bit2 Id2Ex, bit3 Ex2Mem, bit4 Mem2Wb.
// The outputs are combinational from the registered state and the current
// inputs, so every command takes effect in the same cycle it is requested.

module pipe_hazard_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8    // 2**CNT_W must exceed MEM_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              TrapReq,
  input  logic [ADDR_W-1:0] TrapVector,
  input  logic              JumpReqFromEx,
  input  logic [ADDR_W-1:0] JumpAddrFromEx,
  input  logic              LoadUseHazard,
  input  logic              DivStart,
  input  logic              DivDone,
  input  logic              MemReq,
  input  logic              MemAck,
  output logic [4:0]        HoldVec,
  output logic [4:0]        FlushVec,
  output logic              PcRedirect,
  output logic [ADDR_W-1:0] PcRedirectAddr,
  output logic              MemTimeout
);

  // Wait-state FSM encoding.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DIV_WAIT = 2'd2;
  localparam logic [1:0] ST_TRAP     = 2'd3;

  // Per-rule hold/flush patterns, kept in one place so every state uses the
  // same commands for the same hazard.
  localparam logic [4:0] TRAP_FLUSH   = 5'b01110;
  localparam logic [4:0] MEM_HOLD     = 5'b01111;
  localparam logic [4:0] MEM_FLUSH    = 5'b10000;
  localparam logic [4:0] DIV_HOLD     = 5'b00111;
  localparam logic [4:0] DIV_FLUSH    = 5'b01000;
  localparam logic [4:0] JUMP_FLUSH   = 5'b00110;
  localparam logic [4:0] LU_HOLD      = 5'b00011;
  localparam logic [4:0] LU_FLUSH     = 5'b00100;
  localparam logic [4:0] FETCH_FLUSH  = 5'b00010;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]        state;
  logic [1:0]        nextState;
  logic [CNT_W-1:0]  memCnt;
  logic [CNT_W-1:0]  nextMemCnt;

  logic [4:0]        holdRaw;
  logic [4:0]        flushRaw;
  logic              redirRaw;
  logic [ADDR_W-1:0] redirAddrRaw;
  logic              timeoutRaw;

  // Shared request decodes.
  logic memStall;
  logic divStall;
  assign memStall = MemReq && !MemAck;
  assign divStall = DivStart && !DivDone;

  // Next-state and command decode for the current state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch; blocking '=' is correct in
    // combinational logic because later statements must see earlier results.
    holdRaw      = '0;
    flushRaw     = '0;
    redirRaw     = 1'b0;
    redirAddrRaw = '0;
    timeoutRaw   = 1'b0;
    nextState    = state;
    nextMemCnt   = memCnt;

    case (state)
      ST_RUN: begin
        if (TrapReq) begin
          flushRaw     = TRAP_FLUSH;
          redirRaw     = 1'b1;
          redirAddrRaw = TrapVector;
          nextState    = ST_TRAP;
        end else if (memStall) begin
          holdRaw    = MEM_HOLD;
          flushRaw   = MEM_FLUSH;
          nextState  = ST_MEM_WAIT;
          nextMemCnt = CNT_ONE;
        end else if (divStall) begin
          holdRaw   = DIV_HOLD;
          flushRaw  = DIV_FLUSH;
          nextState = ST_DIV_WAIT;
        end else if (JumpReqFromEx) begin
          // The Id instruction is wrong-path, so a jump beats load-use.
          flushRaw     = JUMP_FLUSH;
          redirRaw     = 1'b1;
          redirAddrRaw = JumpAddrFromEx;
        end else if (LoadUseHazard) begin
          holdRaw  = LU_HOLD;
          flushRaw = LU_FLUSH;
        end
      end

      ST_MEM_WAIT: begin
        if (TrapReq) begin
          flushRaw     = TRAP_FLUSH;
          redirRaw     = 1'b1;
          redirAddrRaw = TrapVector;
          nextState    = ST_TRAP;
          nextMemCnt   = '0;
        end else if (MemAck || (memCnt == TIMEOUT_CNT)) begin
          // Mem is released (acked or abandoned); the younger stages are
          // arbitrated as if the Mem stage were satisfied this cycle. A
          // timeout always returns to RUN; the trap unit takes over from there.
          timeoutRaw = !MemAck;
          nextMemCnt = '0;
          nextState  = ST_RUN;
          if (divStall) begin
            holdRaw  = DIV_HOLD;
            flushRaw = DIV_FLUSH;
            if (MemAck) nextState = ST_DIV_WAIT;
          end else if (JumpReqFromEx) begin
            flushRaw     = JUMP_FLUSH;
            redirRaw     = 1'b1;
            redirAddrRaw = JumpAddrFromEx;
          end else if (LoadUseHazard) begin
            holdRaw  = LU_HOLD;
            flushRaw = LU_FLUSH;
          end
        end else begin
          holdRaw    = MEM_HOLD;
          flushRaw   = MEM_FLUSH;
          nextMemCnt = memCnt + CNT_ONE;
        end
      end

      ST_DIV_WAIT: begin
        // The Mem stage only holds bubbles here, so MemReq is not looked at.
        if (TrapReq) begin
          flushRaw     = TRAP_FLUSH;
          redirRaw     = 1'b1;
          redirAddrRaw = TrapVector;
          nextState    = ST_TRAP;
        end else if (DivDone) begin
          nextState = ST_RUN;
          if (JumpReqFromEx) begin
            flushRaw     = JUMP_FLUSH;
            redirRaw     = 1'b1;
            redirAddrRaw = JumpAddrFromEx;
          end else if (LoadUseHazard) begin
            holdRaw  = LU_HOLD;
            flushRaw = LU_FLUSH;
          end
        end else begin
          holdRaw  = DIV_HOLD;
          flushRaw = DIV_FLUSH;
        end
      end

      default: begin
        // ST_TRAP: one cycle to discard the fetch already in flight after the
        // redirect; every request is ignored.
        flushRaw  = FETCH_FLUSH;
        nextState = ST_RUN;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled before the edge.
    if (Rst) begin
      state  <= ST_RUN;
      memCnt <= '0;
    end else begin
      state  <= nextState;
      memCnt <= nextMemCnt;
    end
  end

  // Output stage: reset forces everything low at once, flush masks hold on the
  // same buffer, and the redirect address is zero unless a redirect is issued.
  assign HoldVec        = Rst ? 5'b0 : (holdRaw & ~flushRaw);
  assign FlushVec       = Rst ? 5'b0 : flushRaw;
  assign PcRedirect     = Rst ? 1'b0 : redirRaw;
  assign PcRedirectAddr = (Rst || !redirRaw) ? '0 : redirAddrRaw;
  assign MemTimeout     = Rst ? 1'b0 : timeoutRaw;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: a table of single-cycle vectors that chain
// through the FSM, followed by hand-written multi-cycle sequences for memory
// ack, memory timeout, divide-then-trap and asynchronous reset.

module tb_pipe_hazard_ctrl;

  localparam int AW = 64;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          TrapReq;
  logic [AW-1:0] TrapVector;
  logic          JumpReqFromEx;
  logic [AW-1:0] JumpAddrFromEx;
  logic          LoadUseHazard;
  logic          DivStart;
  logic          DivDone;
  logic          MemReq;
  logic          MemAck;
  logic [4:0]    HoldVec;
  logic [4:0]    FlushVec;
  logic          PcRedirect;
  logic [AW-1:0] PcRedirectAddr;
  logic          MemTimeout;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(
    .ADDR_W     (AW),
    .MEM_TIMEOUT(4),
    .CNT_W      (3)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .TrapReq       (TrapReq),
    .TrapVector    (TrapVector),
    .JumpReqFromEx (JumpReqFromEx),
    .JumpAddrFromEx(JumpAddrFromEx),
    .LoadUseHazard (LoadUseHazard),
    .DivStart      (DivStart),
    .DivDone       (DivDone),
    .MemReq        (MemReq),
    .MemAck        (MemAck),
    .HoldVec       (HoldVec),
    .FlushVec      (FlushVec),
    .PcRedirect    (PcRedirect),
    .PcRedirectAddr(PcRedirectAddr),
    .MemTimeout    (MemTimeout)
  );

  // One cycle of stimulus and its expected outputs.
  typedef struct {
    string         name;
    logic [6:0]    req;   // {trap, jump, loadUse, divStart, divDone, memReq, memAck}
    logic [AW-1:0] tvec;
    logic [AW-1:0] jaddr;
    logic [4:0]    hold;
    logic [4:0]    flush;
    logic          redir;
    logic [AW-1:0] raddr;
    logic          tout;
  } vec_t;

  function automatic vec_t mk(string n, logic [6:0] req, logic [AW-1:0] tv,
                              logic [AW-1:0] ja, logic [4:0] h, logic [4:0] f,
                              logic rd, logic [AW-1:0] ra, logic to);
    vec_t v;
    v.name = n; v.req = req; v.tvec = tv; v.jaddr = ja;
    v.hold = h; v.flush = f; v.redir = rd; v.raddr = ra; v.tout = to;
    return v;
  endfunction

  task automatic check(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    {TrapReq, JumpReqFromEx, LoadUseHazard, DivStart, DivDone, MemReq, MemAck} = v.req;
    TrapVector     = v.tvec;
    JumpAddrFromEx = v.jaddr;
  endtask

  task automatic compare(vec_t v);
    check({v.name, ".hold"},  AW'(HoldVec),    AW'(v.hold));
    check({v.name, ".flush"}, AW'(FlushVec),   AW'(v.flush));
    check({v.name, ".redir"}, AW'(PcRedirect), AW'(v.redir));
    check({v.name, ".raddr"}, PcRedirectAddr,  v.raddr);
    check({v.name, ".tout"},  AW'(MemTimeout), AW'(v.tout));
  endtask

  // Drive just after a rising edge, check at the falling edge, then advance.
  task automatic run_vec(vec_t v);
    drive(v);
    @(negedge Clk);
    compare(v);
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[22];
  vec_t seq[$];

  initial begin
    // Table of chained vectors; state carries from one entry to the next.
    tbl[0]  = mk("idle",           7'b0000000, 0,      0,           5'b00000, 5'b00000, 0, 0,           0);
    tbl[1]  = mk("loaduse",        7'b0010000, 0,      0,           5'b00011, 5'b00100, 0, 0,           0);
    tbl[2]  = mk("idle_noaddr",    7'b0000000, 'hbeef, 'hdead,      5'b00000, 5'b00000, 0, 0,           0);
    tbl[3]  = mk("jump_lu",        7'b0110000, 0,      'h80000040,  5'b00000, 5'b00110, 1, 'h80000040,  0);
    tbl[4]  = mk("jump_only",      7'b0100000, 0,      'h1234,      5'b00000, 5'b00110, 1, 'h1234,      0);
    tbl[5]  = mk("trap_wins",      7'b1110010, 'h200,  'h999,       5'b00000, 5'b01110, 1, 'h200,       0);
    tbl[6]  = mk("trap_cycle",     7'b0110010, 0,      'h999,       5'b00000, 5'b00010, 0, 0,           0);
    tbl[7]  = mk("memack_lu",      7'b0010011, 0,      0,           5'b00011, 5'b00100, 0, 0,           0);
    tbl[8]  = mk("divdone_jump",   7'b0101100, 0,      'h40,        5'b00000, 5'b00110, 1, 'h40,        0);
    tbl[9]  = mk("mem_beats_div",  7'b0001010, 0,      0,           5'b01111, 5'b10000, 0, 0,           0);
    tbl[10] = mk("ack_to_div",     7'b0001011, 0,      0,           5'b00111, 5'b01000, 0, 0,           0);
    tbl[11] = mk("div_ign_mem",    7'b0001010, 0,      0,           5'b00111, 5'b01000, 0, 0,           0);
    tbl[12] = mk("divdone_lu",     7'b0010100, 0,      0,           5'b00011, 5'b00100, 0, 0,           0);
    tbl[13] = mk("idle2",          7'b0000000, 0,      0,           5'b00000, 5'b00000, 0, 0,           0);
    tbl[14] = mk("mem_entry",      7'b0000010, 0,      0,           5'b01111, 5'b10000, 0, 0,           0);
    tbl[15] = mk("mem_wait",       7'b0000010, 0,      0,           5'b01111, 5'b10000, 0, 0,           0);
    tbl[16] = mk("memwait_trap",   7'b1000010, 'h300,  0,           5'b00000, 5'b01110, 1, 'h300,       0);
    tbl[17] = mk("trap_cycle2",    7'b0000010, 0,      0,           5'b00000, 5'b00010, 0, 0,           0);
    tbl[18] = mk("div_entry",      7'b0001000, 0,      0,           5'b00111, 5'b01000, 0, 0,           0);
    tbl[19] = mk("div_wait",       7'b0001000, 0,      0,           5'b00111, 5'b01000, 0, 0,           0);
    tbl[20] = mk("divw_done_jump", 7'b0110100, 0,      'h80,        5'b00000, 5'b00110, 1, 'h80,        0);
    tbl[21] = mk("idle3",          7'b0000000, 0,      0,           5'b00000, 5'b00000, 0, 0,           0);

    // Reset state: outputs stay low while Rst is high, even with requests.
    Rst = 1'b1;
    drive(mk("rst", 7'b1100010, 'h100, 'h200, 0, 0, 0, 0, 0));
    #3;
    compare(mk("reset_hold", 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    @(negedge Clk);
    Rst = 1'b0;
    drive(tbl[0]);
    @(posedge Clk);
    #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // MemReq held, ack on the 4th cycle: three stalled cycles then release.
    seq.delete();
    seq.push_back(mk("ack_s0",  7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    seq.push_back(mk("ack_s1",  7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    seq.push_back(mk("ack_s2",  7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    seq.push_back(mk("ack_rel", 7'b0000011, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    seq.push_back(mk("ack_run", 7'b0000000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    foreach (seq[i]) run_vec(seq[i]);

    // No ack with MEM_TIMEOUT=4: timeout pulse on the 5th stalled cycle, with
    // load-use arbitrated in the release cycle, then back in RUN.
    seq.delete();
    for (int i = 0; i < 4; i++)
      seq.push_back(mk($sformatf("to_s%0d", i), 7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    seq.push_back(mk("to_pulse", 7'b0010010, 0, 0, 5'b00011, 5'b00100, 0, 0, 1));
    seq.push_back(mk("to_run",   7'b0000000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    foreach (seq[i]) run_vec(seq[i]);

    // DivStart, then TrapReq two cycles later.
    seq.delete();
    seq.push_back(mk("dt_div0", 7'b0001000, 0,     0, 5'b00111, 5'b01000, 0, 0,     0));
    seq.push_back(mk("dt_div1", 7'b0001000, 0,     0, 5'b00111, 5'b01000, 0, 0,     0));
    seq.push_back(mk("dt_trap", 7'b1001000, 'h100, 0, 5'b00000, 5'b01110, 1, 'h100, 0));
    seq.push_back(mk("dt_tcyc", 7'b0000000, 0,     0, 5'b00000, 5'b00010, 0, 0,     0));
    seq.push_back(mk("dt_run",  7'b0000000, 0,     0, 5'b00000, 5'b00000, 0, 0,     0));
    foreach (seq[i]) run_vec(seq[i]);

    // Asynchronous reset in the middle of MEM_WAIT.
    run_vec(mk("ar_s0", 7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    run_vec(mk("ar_s1", 7'b0000010, 0, 0, 5'b01111, 5'b10000, 0, 0, 0));
    drive(mk("ar_in", 7'b0000010, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("ar_pre.hold", AW'(HoldVec), AW'(5'b01111));
    #1;
    Rst = 1'b1;
    #1;
    compare(mk("ar_now", 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    TrapReq = 1'b1;
    TrapVector = 'h500;
    #1;
    compare(mk("ar_trapmask", 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
    @(negedge Clk);
    Rst = 1'b0;
    drive(mk("ar_idle", 7'b0000000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk);
    #1;
    for (int i = 0; i < 6; i++)
      run_vec(mk($sformatf("ar_after%0d", i), 7'b0000000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage integer pipeline.
- Arbitrates hold/flush requests from Id (load-use), Ex (jump, divider), Mem (data-bus wait) and trap logic.
- Drives per-register hold and flush commands to the Pc, If2Id, Id2Ex, Ex2Mem and Mem2Wb buffer stages, plus the PC redirect.
- Contains a wait-state FSM and a memory-timeout counter.

Parameters:
- ADDR_W, 64, instruction address width.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before forced release.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- TrapReq  in  1  trap/return taken; instruction is in Mem stage.
- TrapVector  in  ADDR_W  trap target PC.
- JumpReqFromEx  in  1  branch/jump resolved taken in Ex.
- JumpAddrFromEx  in  ADDR_W  jump target.
- LoadUseHazard  in  1  Id instruction depends on load in Ex.
- DivStart  in  1  multi-cycle divide occupying Ex.
- DivDone  in  1  divider result valid this cycle.
- MemReq  in  1  Mem stage bus access pending.
- MemAck  in  1  bus access complete this cycle.
- HoldVec  out  5  hold (keep value); bit0 Pc, bit1 If2Id, bit2 Id2Ex, bit3 Ex2Mem, bit4 Mem2Wb.
- FlushVec  out  5  load bubble/init value; same bit mapping.
- PcRedirect  out  1  load PcRedirectAddr into PC this cycle.
- PcRedirectAddr  out  ADDR_W  redirect target.
- MemTimeout  out  1  one-cycle pulse when MEM_WAIT times out.

Behaviour:
- Reset: state RUN, counter 0. While Rst=1, all outputs are forced to 0 regardless of inputs.
- Outputs are combinational from state and inputs (same-cycle effect). State and counter are registered.
- The flush bit wins over the hold bit of the same register; the block never drives both.

RUN state, first matching rule applies:
- R1 TrapReq:
  - Flush=01110, Hold=0, PcRedirect=1, addr=TrapVector.
  - Next state TRAP.
- R2 MemReq && !MemAck:
  - Hold=01111, Flush=10000.
  - Next state MEM_WAIT, counter<=1.
- R3 DivStart && !DivDone:
  - Hold=00111, Flush=01000.
  - Next state DIV_WAIT.
- R4 JumpReqFromEx:
  - Flush=00110, PcRedirect=1, addr=JumpAddrFromEx.
  - Jump beats load-use because the Id instruction is wrong-path.
- R5 LoadUseHazard:
  - Hold=00011, Flush=00100.
- Otherwise all outputs 0.

MEM_WAIT:
- TrapReq: apply R1, next state TRAP, counter<=0.
- MemAck: release. Evaluate R3-R5 this cycle with Mem satisfied; next state per R3, else RUN; counter<=0.
- Counter==MEM_TIMEOUT without ack:
  - MemTimeout=1, release as for ack, next state RUN.
  - The external trap unit raises TrapReq afterwards.
- Else: Hold=01111, Flush=10000, counter++.

DIV_WAIT:
- TrapReq: apply R1, next state TRAP.
- DivDone: release. Evaluate R4/R5 this cycle; next state RUN.
- Else: Hold=00111, Flush=01000.
- MemReq is ignored in this state because the Mem stage holds bubbles.

TRAP (exactly one cycle):
- Flush=00010 to discard the in-flight fetch, Hold=0.
- All requests ignored. Next state RUN.

Other rules:
- PcRedirectAddr = 0 whenever PcRedirect = 0.
- Async reset in any state returns to RUN, counter 0, outputs 0 immediately.

Test Plan:
- Load-use only: LoadUseHazard=1 for 1 cycle -> HoldVec=00011, FlushVec=00100 that cycle; next cycle all 0.
- Jump plus load-use same cycle, JumpAddrFromEx=0x80000040 -> FlushVec=00110, PcRedirect=1, addr 0x80000040, HoldVec=0.
- MemReq held, MemAck after 3 cycles:
  - Entry cycle and next 2 cycles show HoldVec=01111, FlushVec=10000.
  - Ack cycle shows all 0; state RUN.
- MemReq with no ack, MEM_TIMEOUT=4 -> MemTimeout pulses on 5th stalled cycle, then RUN.
- DivStart, TrapReq 2 cycles later with TrapVector=0x100:
  - DIV_WAIT outputs (Hold 00111, Flush 01000) on first 2 cycles.
  - Then Flush=01110, PcRedirect with addr 0x100.
  - Then one cycle Flush=00010, then all 0.
- Rst asserted mid-MEM_WAIT (asynchronously) -> outputs 0 immediately; after release, MemReq=0 gives all 0 and no MemTimeout.
